ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the EX stage of the pipelined CPU. It feeds the EX/MEM
//  pipeline register and holds the HI/LO architectural registers.
//  While an operation is in flight it asserts stall toward the hazard unit. The hazard unit then
//  freezes IF/ID/EX and clears the EX/MEM register.
//  A pipeline flush aborts any in-flight operation.
// PARAMETERS
//  WIDTH   32   operand and result width. HI and LO are each WIDTH bits.
//  CNT_W   6    iteration counter width. Must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      synchronous, active-high reset
//  flush   in   1      pipeline clear: abort current op, same priority class as floprc clear
//  start   in   1      EX holds a mult/div instruction; sampled only in IDLE
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a       in   WIDTH  rs operand (dividend / multiplicand)
//  b       in   WIDTH  rt operand (divisor / multiplier)
//  hi_we   in   1      MTHI write
//  lo_we   in   1      MTLO write
//  wdata   in   WIDTH  MTHI/MTLO data
//  busy    out  1      operation in flight (state != IDLE)
//  stall   out  1      combinational: busy | (start & IDLE & ~flush)
//  done    out  1      one-cycle pulse; HI/LO updated on this cycle
//  hi      out  WIDTH  HI register (product high / remainder)
//  lo      out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0; all working regs 0.
//    Reset overrides flush, start and writes, including mid-operation.
//  - States: IDLE -> CALC -> FIX -> IDLE.
//    IDLE: start & ~flush at edge E latches |a|,|b| (signed ops) or a,b, the op and the result
//      signs, clears the accumulator; counter=0; goes to CALC.
//    CALC: one shift-add (mult) or restoring shift-subtract (div) step per cycle.
//      Exactly WIDTH cycles (edges E+1..E+WIDTH), then go to FIX.
//    FIX: at edge E+WIDTH+1, apply sign correction and write hi/lo. done=1 for that cycle only.
//      Return to IDLE.
//  - Latency: start seen at edge E -> done high in the cycle after edge E+WIDTH+1 (33 edges for
//    WIDTH=32). Back-to-back: a new start is accepted in the cycle after done.
//  - Signed rules: product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sign of a.
//    Negation is two's complement, truncated to width.
//    DIV MIN/-1 yields lo=0x80000000, hi=0 (natural wrap, no trap).
//  - Divide by zero (b==0), all div ops: still runs full latency; result hi=a, lo=all ones.
//  - flush at any edge while busy: return to IDLE next cycle, no done, hi/lo unchanged.
//    flush & start in IDLE: start ignored.
//  - start while busy: ignored; the op/operands are not re-latched.
//  - hi_we/lo_we: honoured only in IDLE and when not overridden by flush. Both may be set in the
//    same cycle. Ignored while busy.
//    start & hi_we in the same IDLE cycle: the write takes effect; the op begins; the op result
//    later overwrites HI.
//  - Outputs hi/lo hold value between completions. done is never high two cycles in a row.
// STRUCTURE
//  - Shared package cpu_pkg: MDU op encodings (MDU_MULT..MDU_DIVU) and the state encoding
//    (S_IDLE, S_CALC, S_FIX).
//  - One sub-module: mdu_sign_fix. Combinational abs/negate of operands and results, reused at
//    operand latch and in FIX.
//  - Datapath: 2*WIDTH accumulator shared by mult (product) and div ({rem, quot}), plus a WIDTH
//    operand reg and CNT_W counter.
// TESTING
//  1 MULT a=7, b=-3 (0xFFFFFFFD) -> done at edge E+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB;
//    stall high E..E+32.
//  2 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. DIVU 100/7 -> lo=14, hi=2.
//  3 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4 DIVU a=0x1234, b=0 -> full latency, hi=0x1234, lo=0xFFFFFFFF.
//  5 Preload hi=0xAAAA via MTHI. Start MULT, flush at CALC cycle 10 -> busy=0 next cycle,
//    no done, hi=0xAAAA. rst mid-CALC -> hi=lo=0, IDLE.
//  6 Second start pulsed while busy, operands changed -> ignored; first result correct.
//    MTLO while busy ignored. Start in the cycle after done is accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings used by the EX-stage multiply/divide unit.
package cpu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_mul(input logic [1:0] o);
    return ~o[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude extraction and result sign correction for the mult/div unit.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 sa,
  output logic                 sb,
  output logic [WIDTH-1:0]     abs_a,
  output logic [WIDTH-1:0]     abs_b,
  input  logic                 is_mul,
  input  logic                 res_neg,
  input  logic                 rem_neg,
  input  logic [2*WIDTH-1:0]   acc,
  output logic [WIDTH-1:0]     res_hi,
  output logic [WIDTH-1:0]     res_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign sa    = signed_op & a[WIDTH-1];
  assign sb    = signed_op & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  // Divide keeps {remainder, quotient} in the accumulator; each half has its own sign
  assign prod = res_neg ? -acc : acc;
  assign quot = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign res_hi = is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
  assign res_lo = is_mul ? prod[WIDTH-1:0]       : quot;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers; stalls the pipeline while working.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_mul_q, is_mul_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   res_hi, res_lo;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_step;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_op (op_is_signed(op)),
    .a         (a),
    .b         (b),
    .sa        (sa),
    .sb        (sb),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .is_mul    (is_mul_q),
    .res_neg   (res_neg_q),
    .rem_neg   (rem_neg_q),
    .acc       (acc_q),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Shift-add: multiplier sits in the low half and is consumed LSB first
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide; explicit compare keeps divisor==0 well defined (remainder ends as dividend)
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_ge   = (rem_sh >= {1'b0, opnd_q});
  assign div_step = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_mul_d  = is_mul_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_mul_d  = op_is_mul(op);
          opnd_d    = op_is_mul(op) ? abs_a : abs_b;
          acc_d     = {{WIDTH{1'b0}}, (op_is_mul(op) ? abs_b : abs_a)};
          res_neg_d = sa ^ sb;
          rem_neg_d = sa;
          div0_d    = ~op_is_mul(op) & (b == '0);
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = is_mul_q ? mul_step : div_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = res_hi;
        lo_d    = div0_q ? '1 : res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush discards everything this cycle would have committed, in any state
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_mul_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_mul_q  <= is_mul_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy | (start & (state_q == S_IDLE) & ~flush);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_hi, exp_lo;
  logic        prev_done = 1'b0;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, result packed as {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin q = sx * sy; p = q; return p; end
      2'b01: begin p = 64'(x) * 64'(y); return p; end
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no completion", hi, lo);
      end else begin
        chk("result", {hi, lo}, exp_q.pop_front());
      end
      if (prev_done) chk("done_twice", 1'b1, 1'b0);
    end
    prev_done = done;
  end

  // Issue an op now (before the next rising edge) and follow it to done, measuring latency
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name);
    int lat = 0;
    int stall_cnt = 0;
    logic [63:0] e;
    e = model(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    #1;
    if (stall) stall_cnt++;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      #1;
      if (stall) stall_cnt++;
      if (done) break;
    end
    chk({name, "_latency"}, 64'(lat), 64'd34);
    chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'd34);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall, 0);

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, "mult_7_m3");
    idle_cycles(2);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu_max_2");
    run_op(2'b11, 32'd100, 32'd7, "divu_100_7");        // back-to-back: started in done cycle
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(2'b11, 32'h0000_1234, 32'd0, "divu_by_zero");
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, "div_neg_by_zero");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
    idle_cycles(1);
    chk("hold_hi", hi, exp_hi);
    chk("hold_lo", lo, exp_lo);

    // MTHI preload, then an op flushed mid-calculation leaves HI/LO alone
    hi_we = 1'b1; wdata = 32'h0000_AAAA;
    @(negedge clk); hi_we = 1'b0; #1;
    exp_hi = 32'h0000_AAAA;
    chk("mthi", hi, exp_hi);
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    chk("flush_busy", busy, 0);
    idle_cycles(40);
    chk("flush_hi", hi, exp_hi);
    chk("flush_lo", lo, exp_lo);

    // MTLO while busy is dropped
    op = 2'b11; a = 32'd50; b = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000_5555;
    @(negedge clk); lo_we = 1'b0; #1;
    chk("mtlo_busy_ignored", lo, exp_lo);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    chk("mtlo_flush_lo", lo, exp_lo);

    // start together with flush in IDLE never launches
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1; #1;
    chk("start_flush_stall", stall, 0);
    @(negedge clk); start = 1'b0; flush = 1'b0; #1;
    chk("start_flush_busy", busy, 0);

    // Reset in the middle of CALC
    op = 2'b00; a = 32'd123; b = 32'd456; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_busy", busy, 0);

    // Second start while busy with different operands is ignored
    op = 2'b00; a = 32'd123; b = 32'hFFFF_FFD3; start = 1'b1;
    exp_q.push_back(model(2'b00, 32'd123, 32'hFFFF_FFD3));
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    op = 2'b11; a = 32'd999; b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("restart_ignored");

    // start and MTHI in the same IDLE cycle: write lands first, result overwrites later
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_BEEF;
    exp_q.push_back(model(2'b01, 32'd3, 32'd4));
    @(negedge clk); start = 1'b0; hi_we = 1'b0; #1;
    chk("start_mthi_hi", hi, 32'h0000_BEEF);
    wait_done("start_mthi");
    chk("start_mthi_final_hi", hi, 32'd0);

    // Random ops, back-to-back, with zero divisors and MIN/-1 mixed in
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int sel;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 20));
      else if (sel == 3) rb = -32'($urandom_range(1, 20));
      run_op(ro, ra, rb, "random");
    end

    idle_cycles(3);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
